// File: rtl/midi_uart_rx_if.sv
// MIDI IN receiver bus: raw serial line in, framed byte with ready/error strobes out.
// The receiver takes the master side; the downstream decoder (or a test driver) takes the slave side.
interface midi_uart_rx_if;
    logic       MIDI_IN;
    logic [7:0] MIDI_BYTE;
    logic       MIDI_RDY;
    logic       FRAME_ERR;

    modport master (
        input  MIDI_IN,
        output MIDI_BYTE,
        output MIDI_RDY,
        output FRAME_ERR
    );

    modport slave (
        output MIDI_IN,
        input  MIDI_BYTE,
        input  MIDI_RDY,
        input  FRAME_ERR
    );
endinterface

// File: rtl/midi_uart_rx.sv
// 8N1 MIDI receiver: 2-FF synchronizer, OVERSAMPLE clocks per bit, 2-of-3 mid-bit vote.
// Good frames update MIDI_BYTE with a MIDI_RDY strobe; a low stop bit gives FRAME_ERR instead.
module midi_uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic           clk500kHz,
    input  logic           RST_N,
    midi_uart_rx_if.master midi
);
    localparam int            CW   = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] M0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] M1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] M2   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic          sync1_q, sync2_q;
    logic          rx_s, maj_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          s0_q, s0_d, s1_q, s1_d;
    logic [7:0]    byte_q, byte_d;
    logic          rdy_q, rdy_d, err_q, err_d;

    assign rx_s = sync2_q;

    // Two-flop synchronizer for the asynchronous MIDI pin; idles high out of reset.
    always_ff @(posedge clk500kHz or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= midi.MIDI_IN;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic: idle qualification, start validation, data shift, stop check.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        rdy_d     = 1'b0;
        err_d     = 1'b0;
        maj_s     = majority3(s0_q, s1_q, rx_s);

        // The first two votes are captured every bit; only the decision at M2 uses them.
        if (cnt_q == M0) s0_d = rx_s;
        else             s0_d = s0_q;
        if (cnt_q == M1) s1_d = rx_s;
        else             s1_d = s1_q;

        case (state_q)
            WAIT_IDLE: begin
                if (!rx_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            START: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == M2 && maj_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == M2) begin
                    shift_d = {maj_s, shift_q[7:1]};
                end else begin
                    shift_d = shift_q;
                end
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                cnt_d = cnt_q + ONE;
                // Decide mid-stop-bit so the next start edge is never missed.
                if (cnt_q == M2) begin
                    cnt_d = '0;
                    if (maj_s) begin
                        byte_d  = shift_q;
                        rdy_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = WAIT_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk500kHz or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= WAIT_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            byte_q    <= 8'h00;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            byte_q    <= byte_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
        end
    end

    assign midi.MIDI_BYTE = byte_q;
    assign midi.MIDI_RDY  = rdy_q;
    assign midi.FRAME_ERR = err_q;
endmodule

// File: tb/tb_midi_uart_rx.sv
// Bench for midi_uart_rx: builds pin waveforms from bytes and bit rates, expects strobes
// 156 cycles after the pin falling edge for accepted frames and nothing for rejected ones.
`timescale 1ns/1ps
module tb_midi_uart_rx;
    localparam int OS  = 16;
    localparam int LAT = 156;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    midi_uart_rx_if bus();

    midi_uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk500kHz (clk),
        .RST_N     (rst_n),
        .midi      (bus.master)
    );

    always #1000 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] b;
        logic       err;
    } ev_t;

    ev_t        obs[$];
    int         viol = 0;
    logic       prev_strobe = 1'b0;
    logic       wave [0:199];
    int         wave_len;
    logic [7:0] last_byte = 8'h00;

    // Strobe monitor: records every strobe and counts rule violations.
    always @(negedge clk) begin
        if (bus.MIDI_RDY === 1'b1 || bus.FRAME_ERR === 1'b1) begin
            obs.push_back(ev_t'{cyc, bus.MIDI_BYTE, bus.FRAME_ERR});
        end
        if ((bus.MIDI_RDY === 1'b1 && bus.FRAME_ERR === 1'b1) ||
            ((bus.MIDI_RDY === 1'b1 || bus.FRAME_ERR === 1'b1) && prev_strobe)) viol++;
        prev_strobe = (bus.MIDI_RDY === 1'b1 || bus.FRAME_ERR === 1'b1);
    end

    task automatic idle(input int n);
        bus.MIDI_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Bit length is 16*(1000+d)/1000 clocks, so d in per-mille sets the rate error.
    task automatic build_frame(input logic [7:0] b, input int d, input int inv_a,
                               input int inv_b, input logic stop_low);
        wave_len = (160 * (1000 + d) + 999) / 1000;
        for (int k = 0; k < wave_len; k++) begin
            int bp;
            bp = (k * 1000) / (16 * (1000 + d));
            if (bp == 0)      wave[k] = 1'b0;
            else if (bp <= 8) wave[k] = b[bp-1];
            else              wave[k] = ~stop_low;
            if (k == inv_a || k == inv_b) wave[k] = ~wave[k];
        end
    endtask

    task automatic play(input int n, output int fall);
        fall = cyc;
        for (int k = 0; k < n; k++) begin
            bus.MIDI_IN = wave[k];
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int f;
        rst_n = 1'b0;
        bus.MIDI_IN = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.MIDI_BYTE !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", bus.MIDI_BYTE); end
        checks++; if (bus.MIDI_RDY !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", bus.MIDI_RDY); end
        checks++; if (bus.FRAME_ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.FRAME_ERR); end
        rst_n = 1'b1;
        // A start bit only 5 highs after release must be ignored; 0x00 then stop leaves the line idle.
        idle(5);
        obs.delete();
        build_frame(8'h00, 0, -1, -1, 1'b0);
        play(wave_len, f);
        idle(32);
        checks++; if (obs.size() !== 0) begin errors++; $display("FAIL reset_early_start: got %0d strobes want 0", obs.size()); end
        checks++; if (bus.MIDI_BYTE !== 8'h00) begin errors++; $display("FAIL reset_byte_hold: got %h want 00", bus.MIDI_BYTE); end
    endtask

    task automatic test_single;
        int f;
        obs.delete();
        build_frame(8'hB0, 0, -1, -1, 1'b0);
        play(wave_len, f);
        idle(32);
        last_byte = 8'hB0;
        checks++;
        if (obs.size() !== 1) begin
            errors++; $display("FAIL single_count: got %0d strobes want 1", obs.size());
        end else begin
            checks++; if (obs[0].err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", obs[0].err); end
            checks++; if (obs[0].b !== 8'hB0) begin errors++; $display("FAIL single_byte: got %h want b0", obs[0].b); end
            checks++; if (obs[0].cyc !== f + LAT) begin errors++; $display("FAIL single_latency: got %0d want %0d", obs[0].cyc - f, LAT); end
        end
        checks++; if (bus.MIDI_BYTE !== 8'hB0) begin errors++; $display("FAIL single_hold: got %h want b0", bus.MIDI_BYTE); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [0:7];
        int         falls [0:7];
        bytes[0] = 8'hB0; bytes[1] = 8'h4A; bytes[2] = 8'h7F;
        for (int i = 3; i < 8; i++) bytes[i] = 8'($urandom_range(0, 255));
        obs.delete();
        for (int i = 0; i < 8; i++) begin
            build_frame(bytes[i], 0, -1, -1, 1'b0);
            play(wave_len, falls[i]);
        end
        idle(32);
        last_byte = bytes[7];
        checks++;
        if (obs.size() !== 8) begin
            errors++; $display("FAIL b2b_count: got %0d strobes want 8", obs.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs[i].err !== 1'b0 || obs[i].b !== bytes[i] || obs[i].cyc !== falls[i] + LAT) begin
                    errors++;
                    $display("FAIL b2b_frame%0d: got byte %h err %b at +%0d want byte %h err 0 at +%0d",
                             i, obs[i].b, obs[i].err, obs[i].cyc - falls[i], bytes[i], LAT);
                end
            end
        end
    endtask

    task automatic test_glitch;
        int f, len;
        for (int g = 0; g < 4; g++) begin
            len = (g == 0) ? 4 : int'($urandom_range(1, 7));
            obs.delete();
            bus.MIDI_IN = 1'b0;
            repeat (len) @(negedge clk);
            idle(40);
            checks++; if (obs.size() !== 0) begin errors++; $display("FAIL glitch_len%0d: got %0d strobes want 0", len, obs.size()); end
        end
        obs.delete();
        build_frame(8'h90, 0, -1, -1, 1'b0);
        play(wave_len, f);
        idle(20);
        last_byte = 8'h90;
        checks++;
        if (obs.size() !== 1 || obs[0].b !== 8'h90 || obs[0].err !== 1'b0 || obs[0].cyc !== f + LAT) begin
            errors++; $display("FAIL glitch_then_frame: got %0d strobes, first byte %h want 1 strobe byte 90",
                               obs.size(), (obs.size() > 0) ? obs[0].b : 8'h00);
        end
    endtask

    task automatic test_frame_error;
        int f0, f1, f2;
        obs.delete();
        build_frame(8'h55, 0, -1, -1, 1'b1);
        play(wave_len, f0);
        idle(10);
        build_frame(8'h80, 0, -1, -1, 1'b0);
        play(wave_len, f1);
        checks++; if (bus.MIDI_BYTE !== last_byte) begin errors++; $display("FAIL ferr_byte_hold: got %h want %h", bus.MIDI_BYTE, last_byte); end
        idle(20);
        build_frame(8'h80, 0, -1, -1, 1'b0);
        play(wave_len, f2);
        idle(20);
        checks++;
        if (obs.size() !== 2) begin
            errors++; $display("FAIL ferr_count: got %0d strobes want 2", obs.size());
        end else begin
            checks++;
            if (obs[0].err !== 1'b1 || obs[0].b !== last_byte || obs[0].cyc !== f0 + LAT) begin
                errors++; $display("FAIL ferr_strobe: got err %b byte %h at +%0d want err 1 byte %h at +%0d",
                                   obs[0].err, obs[0].b, obs[0].cyc - f0, last_byte, LAT);
            end
            checks++;
            if (obs[1].err !== 1'b0 || obs[1].b !== 8'h80 || obs[1].cyc !== f2 + LAT) begin
                errors++; $display("FAIL ferr_recover: got err %b byte %h at +%0d want err 0 byte 80 at +%0d",
                                   obs[1].err, obs[1].b, obs[1].cyc - f2, LAT);
            end
        end
        last_byte = 8'h80;
    endtask

    task automatic test_majority;
        int         f, pos;
        logic [7:0] b;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                b = 8'h53;
                build_frame(b, 0, 16 * 1 + 8, 16 * 6 + 8, 1'b0);
            end else begin
                b   = 8'($urandom_range(0, 255));
                pos = 16 * int'($urandom_range(1, 8)) + int'($urandom_range(7, 9));
                build_frame(b, 0, pos, -1, 1'b0);
            end
            obs.delete();
            play(wave_len, f);
            idle(20);
            checks++;
            if (obs.size() !== 1 || obs[0].b !== b || obs[0].err !== 1'b0) begin
                errors++; $display("FAIL majority%0d: got %0d strobes byte %h want 1 strobe byte %h",
                                   i, obs.size(), (obs.size() > 0) ? obs[0].b : 8'h00, b);
            end
        end
        last_byte = b;
    endtask

    task automatic test_baud;
        int         f, d;
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            d = (i == 0) ? -30 : (i == 1) ? 30 : int'($urandom_range(0, 60)) - 30;
            b = 8'($urandom_range(0, 255));
            build_frame(b, d, -1, -1, 1'b0);
            obs.delete();
            play(wave_len, f);
            idle(20);
            checks++;
            if (obs.size() !== 1 || obs[0].b !== b || obs[0].err !== 1'b0 || obs[0].cyc !== f + LAT) begin
                errors++; $display("FAIL baud_%0dppt: got %0d strobes byte %h want 1 strobe byte %h",
                                   d, obs.size(), (obs.size() > 0) ? obs[0].b : 8'h00, b);
            end
            last_byte = b;
        end
    endtask

    task automatic test_reset_midframe;
        int f;
        obs.delete();
        build_frame(8'hB0, 0, -1, -1, 1'b0);
        play(16 * 4 + 5, f);
        rst_n = 1'b0;
        bus.MIDI_IN = 1'b1;
        #1;
        checks++; if (bus.MIDI_BYTE !== 8'h00) begin errors++; $display("FAIL rstmid_byte: got %h want 00", bus.MIDI_BYTE); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(200);
        checks++; if (obs.size() !== 0) begin errors++; $display("FAIL rstmid_strobes: got %0d want 0", obs.size()); end
        build_frame(8'hB0, 0, -1, -1, 1'b0);
        play(wave_len, f);
        idle(20);
        checks++;
        if (obs.size() !== 1 || obs[0].b !== 8'hB0 || obs[0].err !== 1'b0 || obs[0].cyc !== f + LAT) begin
            errors++; $display("FAIL rstmid_recover: got %0d strobes byte %h want 1 strobe byte b0",
                               obs.size(), (obs.size() > 0) ? obs[0].b : 8'h00);
        end
        checks++; if (bus.MIDI_BYTE !== 8'hB0) begin errors++; $display("FAIL rstmid_hold: got %h want b0", bus.MIDI_BYTE); end
    endtask

    task automatic test_strobe_rules;
        checks++; if (viol !== 0) begin errors++; $display("FAIL strobe_rules: got %0d violations want 0", viol); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.MIDI_IN = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_majority();
        test_baud();
        test_reset_midframe();
        test_strobe_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
